// File: rtl/fir_result_collector.sv
// Output stage of the FIR datapath: rounds and saturates accumulator results to
// sample width, then queues them in a show-ahead FIFO behind a valid/ready port.
module fir_result_collector #(
    parameter  int WIDTH      = 16,
    parameter  int LENGTH     = 64,
    parameter  int FRAC_SHIFT = 15,
    parameter  int DEPTH      = 8,
    localparam int IN_WIDTH   = 2*WIDTH + $clog2(LENGTH),
    localparam int LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] result,
    input  logic                result_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LVL_W-1:0]    level,
    output logic                sat_flag,
    output logic                overrun_flag
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = IN_WIDTH + 1;

    localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(1) << (FRAC_SHIFT-1);
    localparam logic signed [SUM_W-1:0] MAX_C   = (SUM_W'(1) << (WIDTH-1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] MIN_C   = ~MAX_C;
    localparam logic [WIDTH-1:0]        SAT_HI  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]        SAT_LO  = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [SUM_W-1:0] sum_w;
    logic signed [SUM_W-1:0] shifted_w;
    logic [WIDTH-1:0]        rounded_w;
    logic                    clip_w;

    logic                    s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]        s1_data_q, s1_data_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        count_q, count_d;
    logic                    sat_q, sat_d;
    logic                    ovr_q, ovr_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];

    logic                    pop_w;
    logic                    push_w;

    // Extra top bit keeps the rounding add from wrapping; >>> floors, so the
    // half-LSB bias gives round-half-up.
    always_comb begin
        sum_w     = $signed({result[IN_WIDTH-1], result}) + ROUND_C;
        shifted_w = sum_w >>> FRAC_SHIFT;
        rounded_w = shifted_w[WIDTH-1:0];
        clip_w    = 1'b0;
        if (shifted_w > MAX_C) begin
            rounded_w = SAT_HI;
            clip_w    = 1'b1;
        end else if (shifted_w < MIN_C) begin
            rounded_w = SAT_LO;
            clip_w    = 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        pop_w      = (count_q != '0) && out_ready;
        push_w     = s1_valid_q && ((count_q < LVL_W'(DEPTH)) || pop_w);

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sat_d      = sat_q;
        ovr_d      = ovr_q;
        count_d    = count_q + LVL_W'(push_w) - LVL_W'(pop_w);

        if (push_w) begin
            s1_valid_d = 1'b0;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // A result arriving while stage 1 drains into the FIFO is still taken.
        if (result_valid) begin
            if (!s1_valid_q || push_w) begin
                s1_valid_d = 1'b1;
                s1_data_d  = rounded_w;
                if (clip_w) begin
                    sat_d = 1'b1;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s1_data_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            sat_d      = 1'b0;
            ovr_d      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sat_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sat_q      <= sat_d;
            ovr_q      <= ovr_d;
        end
    end

    // NOTE: the storage array has no reset; count gates every read, so stale
    // entries are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= s1_data_q;
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level        = count_q;
    assign in_ready     = ({1'b0, count_q} + (LVL_W+1)'(s1_valid_q)) < (LVL_W+1)'(DEPTH);
    assign sat_flag     = sat_q;
    assign overrun_flag = ovr_q;

endmodule

// File: tb/tb_fir_result_collector.sv
// Self-checking bench for fir_result_collector: constant vector table, directed
// corner-case sequences and random traffic against a queue-based reference model.
module tb_fir_result_collector;
    localparam int WIDTH      = 16;
    localparam int LENGTH     = 64;
    localparam int FRAC_SHIFT = 15;
    localparam int DEPTH      = 8;
    localparam int IN_WIDTH   = 2*WIDTH + $clog2(LENGTH);
    localparam int LVL_W      = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic                result_valid;
    logic                out_ready;
    logic [IN_WIDTH-1:0] result;
    logic                in_ready;
    logic                out_valid;
    logic [WIDTH-1:0]    out_data;
    logic [LVL_W-1:0]    level;
    logic                sat_flag;
    logic                overrun_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_result_collector #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .FRAC_SHIFT(FRAC_SHIFT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .result(result), .result_valid(result_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .sat_flag(sat_flag), .overrun_flag(overrun_flag)
    );

    // Reference model: a queue of rounded samples plus an optional stage-1 slot.
    int m_q[$];
    bit m_s1v;
    int m_s1d;
    bit m_sat;
    bit m_ovr;

    typedef struct {
        longint          r;
        logic [WIDTH-1:0] exp;
        bit              sat;
    } rvec_t;
    rvec_t vecs[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_round(longint r, output bit clip);
        longint v;
        longint hi = (longint'(1) << (WIDTH-1)) - 1;
        longint lo = -(longint'(1) << (WIDTH-1));
        v = (r + (longint'(1) << (FRAC_SHIFT-1))) >>> FRAC_SHIFT;
        clip = 1'b0;
        if (v > hi) begin v = hi; clip = 1'b1; end
        if (v < lo) begin v = lo; clip = 1'b1; end
        return int'(v);
    endfunction

    task automatic model_step();
        bit pop, adv, clip;
        if (rst || flush) begin
            m_q.delete();
            m_s1v = 0; m_s1d = 0; m_sat = 0; m_ovr = 0;
            return;
        end
        pop = (m_q.size() != 0) && out_ready;
        adv = m_s1v && (m_q.size() < DEPTH || pop);
        if (pop) void'(m_q.pop_front());
        if (adv) begin
            m_q.push_back(m_s1d);
            m_s1v = 0;
        end
        if (result_valid) begin
            if (!m_s1v) begin
                m_s1d = ref_round(longint'($signed(result)), clip);
                m_s1v = 1;
                if (clip) m_sat = 1;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic compare_all(string tag);
        logic [WIDTH-1:0] head;
        head = (m_q.size() != 0) ? WIDTH'(m_q[0]) : '0;
        check({tag, ".level"},     64'(level),        64'(m_q.size()));
        check({tag, ".out_valid"}, 64'(out_valid),    64'(m_q.size() != 0));
        check({tag, ".out_data"},  64'(out_data),     64'(head));
        check({tag, ".in_ready"},  64'(in_ready),     64'((m_q.size() + int'(m_s1v)) < DEPTH));
        check({tag, ".sat_flag"},  64'(sat_flag),     64'(m_sat));
        check({tag, ".overrun"},   64'(overrun_flag), 64'(m_ovr));
    endtask

    task automatic drive(bit rv, longint r, bit ordy, bit fl);
        result_valid = rv;
        result       = IN_WIDTH'(r);
        out_ready    = ordy;
        flush        = fl;
    endtask

    task automatic step(string tag);
        @(posedge clk);
        #1;
        model_step();
        compare_all(tag);
    endtask

    task automatic do_flush();
        drive(0, 0, 0, 1);
        step("flush");
        flush = 0;
    endtask

    initial begin
        vecs.push_back(rvec_t'{r: 16384,                     exp: 16'h0001, sat: 0});
        vecs.push_back(rvec_t'{r: 16383,                     exp: 16'h0000, sat: 0});
        vecs.push_back(rvec_t'{r: -16384,                    exp: 16'h0000, sat: 0});
        vecs.push_back(rvec_t'{r: -16385,                    exp: 16'hFFFF, sat: 0});
        vecs.push_back(rvec_t'{r: longint'(1) << 31,         exp: 16'h7FFF, sat: 1});
        vecs.push_back(rvec_t'{r: -(longint'(1) << 31),      exp: 16'h8000, sat: 1});
        vecs.push_back(rvec_t'{r: 1073741823,                exp: 16'h7FFF, sat: 1});
        vecs.push_back(rvec_t'{r: longint'(32767) << 15,     exp: 16'h7FFF, sat: 0});
        vecs.push_back(rvec_t'{r: -(longint'(32768) << 15),  exp: 16'h8000, sat: 0});
        vecs.push_back(rvec_t'{r: (longint'(100) << 15) + 16384, exp: 16'd101, sat: 0});

        rst = 1;
        drive(0, 0, 0, 0);
        step("reset");
        step("reset2");
        check("reset.out_data", 64'(out_data), 64'h0);
        check("reset.in_ready", 64'(in_ready), 64'h1);
        rst = 0;

        // Rounding / saturation table, each vector from an empty FIFO.
        foreach (vecs[i]) begin
            do_flush();
            drive(1, vecs[i].r, 0, 0);
            step("vec_cap");
            check("vec.latency_n1", 64'(out_valid), 64'h0);
            drive(0, 0, 0, 0);
            step("vec_fifo");
            check("vec.out_valid", 64'(out_valid), 64'h1);
            check("vec.out_data",  64'(out_data),  64'(vecs[i].exp));
            check("vec.sat_flag",  64'(sat_flag),  64'(vecs[i].sat));
            drive(0, 0, 1, 0);
            step("vec_pop");
        end

        // Fill to eight, then drain in order.
        do_flush();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, longint'(i) << 15, 0, 0);
            step("fill");
        end
        check("fill.in_ready_cnt_s1", 64'(in_ready), 64'h0);
        drive(0, 0, 0, 0);
        step("fill_idle");
        check("fill.level8", 64'(level), 64'(DEPTH));
        for (int i = 1; i <= DEPTH; i++) begin
            check("drain.head", 64'(out_data), 64'(i));
            drive(0, 0, 1, 0);
            step("drain");
        end
        check("drain.level0", 64'(level), 64'h0);

        // Overrun: full FIFO with 9 parked in stage 1, then one extra result.
        do_flush();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            drive(1, longint'(i) << 15, 0, 0);
            step("ovr_fill");
        end
        drive(1, longint'(77) << 15, 0, 0);
        step("ovr_drop");
        check("ovr.flag",  64'(overrun_flag), 64'h1);
        check("ovr.level", 64'(level),        64'(DEPTH));
        check("ovr.head",  64'(out_data),     64'h1);
        drive(0, 0, 1, 0);
        step("ovr_pop");
        check("ovr.level_after_pop", 64'(level), 64'(DEPTH));
        check("ovr.head_after_pop",  64'(out_data), 64'h2);
        for (int i = 2; i <= DEPTH + 1; i++) begin
            check("ovr_drain.head", 64'(out_data), 64'(i));
            step("ovr_drain");
        end

        // Simultaneous push/pop at level 1, then a 20-pair wrap run.
        do_flush();
        drive(1, longint'(11) << 15, 0, 0);
        step("sim_a");
        drive(1, longint'(12) << 15, 0, 0);
        step("sim_b");
        check("sim.level1", 64'(level), 64'h1);
        drive(0, 0, 1, 0);
        step("sim_pp");
        check("sim.level_pp", 64'(level),    64'h1);
        check("sim.head_pp",  64'(out_data), 64'd12);
        for (int i = 0; i < 20; i++) begin
            drive(1, longint'(200 + i) << 15, 1, 0);
            step("wrap");
        end
        drive(0, 0, 1, 0);
        repeat (3) step("wrap_tail");

        // Flush, reset and reset-over-flush mid-stream at level 5 with stage 1 valid.
        for (int mode = 0; mode < 3; mode++) begin
            do_flush();
            for (int i = 1; i <= 6; i++) begin
                drive(1, (i == 3) ? (longint'(1) << 33) : (longint'(i) << 15), 0, 0);
                step("mid_fill");
            end
            check("mid.level5", 64'(level), 64'h5);
            check("mid.sat_set", 64'(sat_flag), 64'h1);
            rst = (mode != 0);
            drive(1, longint'(9) << 15, 0, mode != 1);
            step("mid_clear");
            rst = 0;
            check("mid.level0",    64'(level),        64'h0);
            check("mid.out_valid", 64'(out_valid),    64'h0);
            check("mid.out_data",  64'(out_data),     64'h0);
            check("mid.flags",     64'({sat_flag, overrun_flag}), 64'h0);
            check("mid.in_ready",  64'(in_ready),     64'h1);
            drive(0, 0, 1, 0);
            step("mid_after");
            check("mid.no_ghost", 64'(level), 64'h0);
        end

        // Random traffic against the model.
        do_flush();
        for (int i = 0; i < 3000; i++) begin
            longint r;
            case ($urandom_range(0, 2))
                0: begin
                    r = longint'({$urandom, $urandom});
                    r = (r <<< (64 - IN_WIDTH)) >>> (64 - IN_WIDTH);
                end
                1: r = longint'($urandom_range(0, 1 << 23)) - (longint'(1) << 22);
                default: r = ($urandom_range(0, 1) ? longint'(32767) : -longint'(32768)) * 32768
                             + longint'($urandom_range(0, 65536)) - 32768;
            endcase
            drive($urandom_range(0, 1), r, $urandom_range(0, 9) < 6, $urandom_range(0, 299) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
